// File: rtl/fp16_drv_pkg.sv
// Shared types and fp16 constants for the fp16 operation driver.
package fp16_drv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSendA,
        StSendB,
        StWaitZ,
        StResult
    } drv_state_e;

    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_QNAN = 16'hFE00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;

endpackage

// File: rtl/fp16_op_fifo.sv
// Operand FIFO: power-of-two depth, show-ahead read data, registered full/empty/count.
module fp16_op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fp16_op_driver.sv
// Feeds queued fp16 operand pairs to an ack-strobe arithmetic unit and returns tagged results.
module fp16_op_driver
    import fp16_drv_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    input  logic [TAG_W-1:0] op_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_z,
    output logic [TAG_W-1:0] res_tag,
    output logic [15:0]      unit_a,
    input  logic             unit_a_ack,
    output logic [15:0]      unit_b,
    input  logic             unit_b_ack,
    input  logic [15:0]      unit_z,
    input  logic             unit_z_stb,
    output logic             unit_z_ack,
    output logic             busy,
    output logic             err_proto,
    output logic             err_timeout,
    output logic [15:0]      ops_done
);
    localparam int unsigned FW = 32 + TAG_W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WdogLimit = WW'(TIMEOUT);

    drv_state_e       state_q, state_d;
    logic [15:0]      cur_a_q, cur_a_d, cur_b_q, cur_b_d;
    logic [15:0]      res_z_q, res_z_d, ops_done_q, ops_done_d;
    logic [TAG_W-1:0] cur_tag_q, cur_tag_d, res_tag_q, res_tag_d;
    logic             res_valid_q, res_valid_d, z_ack_q, z_ack_d;
    logic             err_proto_q, err_proto_d, err_timeout_q, err_timeout_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]    fifo_rdata;
    logic [CW-1:0]    fifo_count;

    // op_ready comes from the registered count only, so a full FIFO rejects even while popping.
    assign op_ready  = !fifo_full;
    assign fifo_push = op_valid && op_ready;

    fp16_op_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(FW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .wdata({op_tag, op_a, op_b}),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        cur_a_d       = cur_a_q;
        cur_b_d       = cur_b_q;
        cur_tag_d     = cur_tag_q;
        res_z_d       = res_z_q;
        res_tag_d     = res_tag_q;
        res_valid_d   = res_valid_q;
        z_ack_d       = z_ack_q;
        ops_done_d    = ops_done_q;
        err_timeout_d = err_timeout_q;
        wdog_d        = wdog_q;
        fifo_pop      = 1'b0;
        err_proto_d   = err_proto_q
                      || (unit_a_ack && (state_q != StSendA))
                      || (unit_b_ack && (state_q != StSendB));

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StSendA;
                end
            end
            StSendA: begin
                if (!err_timeout_q && unit_a_ack) begin
                    state_d = StSendB;
                end
            end
            StSendB: begin
                if (!err_timeout_q && unit_b_ack) begin
                    state_d = StWaitZ;
                    z_ack_d = 1'b1;
                end
            end
            StWaitZ: begin
                if (!err_timeout_q && unit_z_stb && z_ack_q) begin
                    res_z_d     = unit_z;
                    res_tag_d   = cur_tag_q;
                    res_valid_d = 1'b1;
                    z_ack_d     = 1'b0;
                    ops_done_d  = ops_done_q + 16'd1;
                    state_d     = StResult;
                end
            end
            StResult: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = StSendA;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (fifo_pop) begin
            {cur_tag_d, cur_a_d, cur_b_d} = fifo_rdata;
        end

        // Once expired the watchdog freezes along with the FSM until reset.
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (!err_timeout_q && (state_q inside {StSendA, StSendB, StWaitZ})) begin
            wdog_d = wdog_q + WW'(1);
            if (wdog_d == WdogLimit) begin
                err_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cur_a_q       <= '0;
            cur_b_q       <= '0;
            cur_tag_q     <= '0;
            res_z_q       <= '0;
            res_tag_q     <= '0;
            res_valid_q   <= 1'b0;
            z_ack_q       <= 1'b0;
            ops_done_q    <= '0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            cur_a_q       <= cur_a_d;
            cur_b_q       <= cur_b_d;
            cur_tag_q     <= cur_tag_d;
            res_z_q       <= res_z_d;
            res_tag_q     <= res_tag_d;
            res_valid_q   <= res_valid_d;
            z_ack_q       <= z_ack_d;
            ops_done_q    <= ops_done_d;
            err_proto_q   <= err_proto_d;
            err_timeout_q <= err_timeout_d;
            wdog_q        <= wdog_d;
        end
    end

    assign unit_a      = cur_a_q;
    assign unit_b      = cur_b_q;
    assign unit_z_ack  = z_ack_q;
    assign res_valid   = res_valid_q;
    assign res_z       = res_z_q;
    assign res_tag     = res_tag_q;
    assign ops_done    = ops_done_q;
    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (fifo_count != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_fp16_op_driver.sv
// Randomized bench for fp16_op_driver with a subtract-unit responder and an in-order scoreboard.
module tb_fp16_op_driver;
    import fp16_drv_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             op_valid, op_ready;
    logic [15:0]      op_a, op_b;
    logic [TAG_W-1:0] op_tag;
    logic             res_valid, res_ready;
    logic [15:0]      res_z;
    logic [TAG_W-1:0] res_tag;
    logic [15:0]      unit_a, unit_b, unit_z;
    logic             unit_a_ack, unit_b_ack, unit_z_stb, unit_z_ack;
    logic             busy, err_proto, err_timeout;
    logic [15:0]      ops_done;

    always #5 clk = ~clk;

    fp16_op_driver #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_tag     (op_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_z      (res_z),
        .res_tag    (res_tag),
        .unit_a     (unit_a),
        .unit_a_ack (unit_a_ack),
        .unit_b     (unit_b),
        .unit_b_ack (unit_b_ack),
        .unit_z     (unit_z),
        .unit_z_stb (unit_z_stb),
        .unit_z_ack (unit_z_ack),
        .busy       (busy),
        .err_proto  (err_proto),
        .err_timeout(err_timeout),
        .ops_done   (ops_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pushed   = 0;
    int got      = 0;
    int served   = 0;
    int exp_done = 0;
    bit resp_inject_b = 1'b0;
    logic [15:0]      exp_z_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic real fp16_to_real(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) m = real'(h[9:0]) * (2.0 ** (-24));
        else        m = real'({1'b1, h[9:0]}) * (2.0 ** (e - 25));
        return h[15] ? -m : m;
    endfunction

    // Only used on values that are exactly representable as normal fp16 (or zero).
    function automatic logic [15:0] real_to_fp16(input real r);
        logic s;
        int   e;
        real  m;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {s, 5'(e), 10'(int'((m - 1.0) * 1024.0))};
    endfunction

    function automatic logic [15:0] fp16_sub(input logic [15:0] a, input logic [15:0] b);
        return real_to_fp16(fp16_to_real(a) - fp16_to_real(b));
    endfunction

    function automatic logic [15:0] int_to_fp16(input int v);
        return real_to_fp16(real'(v));
    endfunction

    // Host-side scoreboard: every result handshake must match the oldest issued operation.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            check_eq("res_expected", 64'(exp_z_q.size() != 0), 64'd1);
            if (exp_z_q.size() != 0) begin
                check_eq("res_z", res_z, exp_z_q.pop_front());
                check_eq("res_tag", res_tag, exp_tag_q.pop_front());
            end
            got++;
            exp_done++;
        end
    end

    task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t);
        int k = 0;
        op_a = a; op_b = b; op_tag = t; op_valid = 1'b1;
        exp_z_q.push_back(fp16_sub(a, b));
        exp_tag_q.push_back(t);
        do begin @(negedge clk); k++; end while (!op_ready && k < 400);
        check_eq("push_accept", op_ready, 1'b1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        pushed++;
    endtask

    // Subtract-unit responder: one operation at a time, random ack latencies.
    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            logic [15:0] ua, ub;
            while (!(pushed > served && got == served) && k < 1000) begin
                @(posedge clk); #1; k++;
            end
            check_eq("serve_start", 64'(pushed > served && got == served), 64'd1);
            @(posedge clk); #1;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (resp_inject_b) begin
                unit_b_ack = 1'b1;
                @(posedge clk); #1;
                unit_b_ack = 1'b0;
                resp_inject_b = 1'b0;
                check_eq("err_proto_set", err_proto, 1'b1);
            end
            ua = unit_a;
            unit_a_ack = 1'b1;
            @(posedge clk); #1;
            unit_a_ack = 1'b0;
            check_eq("unit_a_stable", unit_a, ua);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            ub = unit_b;
            unit_b_ack = 1'b1;
            @(posedge clk); #1;
            unit_b_ack = 1'b0;
            check_eq("unit_b_stable", unit_b, ub);
            k = 0;
            while (!unit_z_ack && k < 100) begin @(posedge clk); #1; k++; end
            check_eq("z_ack_raised", unit_z_ack, 1'b1);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            unit_z = fp16_sub(ua, ub);
            unit_z_stb = 1'b1;
            @(posedge clk); #1;
            unit_z_stb = 1'b0;
            unit_z = 16'($urandom);
            served++;
        end
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((got != pushed || res_valid) && k < 3000) begin @(posedge clk); #1; k++; end
        check_eq({tag, "_drained"}, 64'(got), 64'(pushed));
        check_eq({tag, "_idle"}, busy, 1'b0);
        check_eq({tag, "_ops_done"}, ops_done, 16'(exp_done));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_op_ready"}, op_ready, 1'b1);
        check_eq({tag, "_res_valid"}, res_valid, 1'b0);
        check_eq({tag, "_res_z"}, res_z, 16'h0);
        check_eq({tag, "_res_tag"}, res_tag, 4'h0);
        check_eq({tag, "_unit_a"}, unit_a, 16'h0);
        check_eq({tag, "_unit_b"}, unit_b, 16'h0);
        check_eq({tag, "_z_ack"}, unit_z_ack, 1'b0);
        check_eq({tag, "_err_proto"}, err_proto, 1'b0);
        check_eq({tag, "_err_timeout"}, err_timeout, 1'b0);
        check_eq({tag, "_ops_done"}, ops_done, 16'h0);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic clear_model();
        exp_z_q.delete();
        exp_tag_q.delete();
        pushed = 0; got = 0; served = 0; exp_done = 0;
    endtask

    task automatic manual_ab();
        @(posedge clk); #1;
        unit_a_ack = 1'b1;
        @(posedge clk); #1;
        unit_a_ack = 1'b0;
        unit_b_ack = 1'b1;
        @(posedge clk); #1;
        unit_b_ack = 1'b0;
    endtask

    logic [15:0]      hold_z, hold_a;
    logic [TAG_W-1:0] hold_tag;
    int               target;

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; op_tag = '0; res_ready = 1'b0;
        unit_a_ack = 1'b0; unit_b_ack = 1'b0; unit_z_stb = 1'b0; unit_z = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("reset");

        // Single op: 1.0 - 0.5 = 0.5
        res_ready = 1'b1;
        fork
            push_op(FP16_ONE, 16'h3800, 4'd5);
            serve(1);
        join
        wait_drain("single");

        // Burst: five accepted before the FIFO fills (one popped into SEND_A).
        for (int i = 0; i < 5; i++) begin
            push_op(int_to_fp16($urandom_range(0, 1023)), int_to_fp16($urandom_range(0, 1023)), 4'(i));
        end
        check_eq("burst_full", op_ready, 1'b0);
        check_eq("burst_busy", busy, 1'b1);
        fork
            push_op(int_to_fp16($urandom_range(0, 1023)), int_to_fp16($urandom_range(0, 1023)), 4'd5);
            serve(6);
        join
        wait_drain("burst");

        // Backpressure: result must hold and no further pop may occur.
        res_ready = 1'b0;
        fork
            for (int i = 0; i < 3; i++) begin
                push_op(int_to_fp16(200 + 10 * i + $urandom_range(0, 9)),
                        int_to_fp16($urandom_range(0, 150)), 4'(8 + i));
            end
            serve(3);
            begin
                int k = 0;
                while (!res_valid && k < 500) begin @(posedge clk); #1; k++; end
                check_eq("bp_res_valid", res_valid, 1'b1);
                hold_z = res_z; hold_tag = res_tag; hold_a = unit_a;
                repeat (20) begin
                    @(posedge clk); #1;
                    check_eq("bp_hold", {res_valid, res_z, res_tag, unit_a},
                             {1'b1, hold_z, hold_tag, hold_a});
                end
                res_ready = 1'b1;
            end
        join
        wait_drain("backpressure");
        check_eq("no_proto_err", err_proto, 1'b0);

        // Protocol error: stray b-ack during SEND_A; the operation still completes.
        resp_inject_b = 1'b1;
        fork
            push_op(int_to_fp16(77), int_to_fp16(300), 4'd3);
            serve(1);
        join
        wait_drain("proto");
        check_eq("err_proto_sticky", err_proto, 1'b1);

        // Random traffic with random result backpressure.
        target = got + 20;
        fork
            for (int i = 0; i < 20; i++) begin
                push_op(int_to_fp16($urandom_range(0, 1023)), int_to_fp16($urandom_range(0, 1023)),
                        4'($urandom));
            end
            serve(20);
            begin
                int k = 0;
                while (got < target && k < 5000) begin
                    @(posedge clk); #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                    k++;
                end
                res_ready = 1'b1;
            end
        join
        wait_drain("random");
        check_eq("random_no_timeout", err_timeout, 1'b0);

        // Timeout: unit never strobes z.
        push_op(int_to_fp16(5), int_to_fp16(3), 4'd1);
        manual_ab();
        check_eq("to_in_waitz", unit_z_ack, 1'b1);
        repeat (63) @(posedge clk);
        #1 check_eq("to_not_yet", err_timeout, 1'b0);
        @(posedge clk); #1;
        check_eq("to_expired", err_timeout, 1'b1);
        unit_z = int_to_fp16(2);
        unit_z_stb = 1'b1;
        @(posedge clk); #1;
        unit_z_stb = 1'b0;
        check_eq("to_stays_waitz", {unit_z_ack, res_valid, busy}, {1'b1, 1'b0, 1'b1});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
        check_eq("to_cleared", err_timeout, 1'b0);

        // Asynchronous reset between edges while in WAIT_Z.
        push_op(int_to_fp16(9), int_to_fp16(4), 4'd7);
        manual_ab();
        check_eq("ar_in_waitz", unit_z_ack, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
        check_reset_vals("post_rst");
        fork
            push_op(int_to_fp16(600), int_to_fp16(25), 4'd2);
            serve(1);
        join
        wait_drain("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        n_errors++;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
